// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: state encoding, default
// widths and the word-alignment helper.
package mem_access_unit_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF   = 5;

    // Low address bits of a word-aligned byte address
    localparam logic [1:0] ALIGN_OK = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == ALIGN_OK;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the memory access unit and data memory.
interface mem_access_unit_if
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Transaction watchdog. Reloads with TIMEOUT-1 while cleared and counts down
// while enabled; expire flags the last permitted wait cycle.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;

    // Down-counter, held at zero once it reaches terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// EX/MEM consumer: issues one load/store at a time to a variable-latency
// data memory, stalls the pipeline while it waits, aborts on timeout.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | no transaction; decode in_* and issue or pass through
//  BUSY  | mem_req held, waiting for mem_ack or watchdog expiry
//  DONE  | result presented for one cycle, pipeline released
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_rd,
    input  logic              in_wr,
    input  logic [DATA_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              stall_o,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_rdata,
    output logic              misalign_o,
    output logic              timeout_o,
    mem_access_unit_if.master mem
);

    state_t            state;
    logic [DATA_W-1:0] rdata_q;
    logic              timeout_q;
    logic              expire;
    logic              is_mem;
    logic              aligned;
    logic              issue;

    assign is_mem  = in_valid & (in_rd | in_wr);
    assign aligned = word_aligned(in_addr[1:0]);
    assign issue   = (state == ST_IDLE) & is_mem & aligned;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_IDLE),
        .enable (state == ST_BUSY),
        .expire (expire)
    );

    // Transaction FSM with registered bus outputs and captured load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            rdata_q       <= '0;
            timeout_q     <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (issue) begin
                        mem.mem_req   <= 1'b1;
                        // A simultaneous rd/wr request is treated as a store
                        mem.mem_we    <= in_wr;
                        mem.mem_addr  <= {in_addr[DATA_W-1:2], ALIGN_OK};
                        mem.mem_wdata <= in_wdata;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Ack takes priority over a watchdog expiry in the same cycle
                    if (mem.mem_ack) begin
                        rdata_q     <= mem.mem_we ? '0 : mem.mem_rdata;
                        mem.mem_req <= 1'b0;
                        state       <= ST_DONE;
                    end else if (expire) begin
                        rdata_q     <= '0;
                        mem.mem_req <= 1'b0;
                        timeout_q   <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    mem.mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline-facing strobes decoded from state and the current instruction
    always_comb begin
        stall_o    = 1'b0;
        out_valid  = 1'b0;
        out_rdata  = '0;
        misalign_o = 1'b0;
        unique case (state)
            ST_IDLE: begin
                stall_o    = issue;
                misalign_o = is_mem & ~aligned;
                out_valid  = in_valid & (~is_mem | ~aligned);
            end
            ST_BUSY: begin
                stall_o = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_rdata = rdata_q;
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Transaction-level bench for mem_access_unit: directed table, a reset /
// spurious-ack sequence, then randomized transactions against a model.
module tb_mem_access_unit;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int BOUND   = 40;

    logic              clk;
    logic              rst_n;
    logic              in_valid, in_rd, in_wr;
    logic [DATA_W-1:0] in_addr, in_wdata;
    logic              stall_o, out_valid, misalign_o, timeout_o;
    logic [DATA_W-1:0] out_rdata;

    mem_access_unit_if #(.DATA_W(DATA_W)) bus ();

    mem_access_unit #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_rd      (in_rd),
        .in_wr      (in_wr),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .stall_o    (stall_o),
        .out_valid  (out_valid),
        .out_rdata  (out_rdata),
        .misalign_o (misalign_o),
        .timeout_o  (timeout_o),
        .mem        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rd, wr;
        logic [31:0] addr, wdata, rdata;
        int          lat;        // BUSY cycle in which memory acks; 0 = never
        int          e_ov;       // number of out_valid cycles
        logic [31:0] e_rdata;
        int          e_stall;    // cycles with stall_o high
        int          e_req;      // cycles with mem_req high
        int          e_mis;      // misalign pulses
        int          e_to;       // timeout_o after the transaction
        int          e_ovcyc;    // cycle of out_valid relative to presentation; -1 none
    } vec_t;

    typedef struct {
        int          ov, stall, req, mis, to, ovcyc, bus_bad;
        logic [31:0] rdata;
    } obs_t;

    int n_pass  = 0;
    int n_total = 0;
    bit model_to = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Expected outcome of one instruction, from the block's rules at transaction level
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        e.e_ov = 0; e.e_rdata = 0; e.e_stall = 0; e.e_req = 0; e.e_mis = 0; e.e_ovcyc = -1;
        if (v.valid) begin
            e.e_ov = 1;
            e.e_ovcyc = 0;
            if ((v.rd || v.wr) && v.addr[1:0] != 2'b00) begin
                e.e_mis = 1;
            end else if (v.rd || v.wr) begin
                if (v.lat >= 1 && v.lat <= TIMEOUT) begin
                    e.e_req = v.lat;
                    e.e_rdata = v.wr ? 32'h0 : v.rdata;
                end else begin
                    e.e_req = TIMEOUT;
                    model_to = 1'b1;
                end
                e.e_stall = e.e_req + 1;
                e.e_ovcyc = e.e_req + 1;
            end
        end
        e.e_to = int'(model_to);
        return e;
    endfunction

    task automatic run_txn(input vec_t v, output obs_t o);
        int  n_req;
        bit  done;
        o = '{default: 0};
        o.ovcyc = -1;
        @(posedge clk); #1;
        in_valid = v.valid; in_rd = v.rd; in_wr = v.wr;
        in_addr = v.addr; in_wdata = v.wdata;
        bus.mem_ack = 1'b0;
        n_req = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < BOUND && !done; cyc++) begin
            @(negedge clk);
            if (stall_o) o.stall++;
            if (misalign_o) o.mis++;
            if (bus.mem_req) begin
                n_req++;
                o.req++;
                if (bus.mem_we !== v.wr || bus.mem_addr !== v.addr ||
                    (v.wr && bus.mem_wdata !== v.wdata)) o.bus_bad++;
            end
            bus.mem_ack   = bus.mem_req && (n_req == v.lat);
            bus.mem_rdata = v.rdata;
            if (out_valid) begin
                o.ov++;
                o.rdata = out_rdata;
                o.ovcyc = cyc;
                done = 1'b1;
            end
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (done) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) o.ov++;
            if (bus.mem_req) o.req++;
        end
        o.to = int'(timeout_o);
    endtask

    task automatic check_txn(input string tag, input vec_t e, input obs_t o);
        chk({tag, " out_valid_count"}, o.ov, e.e_ov);
        chk({tag, " out_rdata"}, o.rdata, e.e_rdata);
        chk({tag, " stall_cycles"}, o.stall, e.e_stall);
        chk({tag, " req_cycles"}, o.req, e.e_req);
        chk({tag, " misalign"}, o.mis, e.e_mis);
        chk({tag, " timeout_o"}, o.to, e.e_to);
        chk({tag, " out_valid_cycle"}, o.ovcyc, e.e_ovcyc);
        chk({tag, " bus_stable"}, o.bus_bad, 0);
    endtask

    initial begin
        vec_t  tbl[$];
        vec_t  v, e;
        obs_t  o;

        rst_n = 1'b0;
        in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0;
        in_addr = '0; in_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;

        //          valid rd wr addr          wdata         rdata         lat ov rdata        stl req mis to ovcyc
        tbl.push_back('{1, 1, 0, 32'h100, 32'h0,        32'hCAFEF00D, 3,  1, 32'hCAFEF00D, 4,  3,  0, 0, 4});
        tbl.push_back('{1, 0, 1, 32'h204, 32'h12345678, 32'hDEADBEEF, 1,  1, 32'h0,        2,  1,  0, 0, 2});
        tbl.push_back('{1, 1, 0, 32'h102, 32'h0,        32'h55555555, 1,  1, 32'h0,        0,  0,  1, 0, 0});
        tbl.push_back('{1, 1, 1, 32'h300, 32'hA5A5A5A5, 32'h99999999, 2,  1, 32'h0,        3,  2,  0, 0, 3});
        tbl.push_back('{1, 1, 0, 32'h040, 32'h0,        32'h0BADC0DE, 16, 1, 32'h0BADC0DE, 17, 16, 0, 0, 17});
        tbl.push_back('{1, 1, 0, 32'h044, 32'h0,        32'h11112222, 15, 1, 32'h11112222, 16, 15, 0, 0, 16});
        tbl.push_back('{1, 0, 0, 32'h003, 32'h0,        32'h33333333, 1,  1, 32'h0,        0,  0,  0, 0, 0});
        tbl.push_back('{0, 1, 0, 32'h080, 32'h0,        32'h44444444, 1,  0, 32'h0,        0,  0,  0, 0, -1});
        tbl.push_back('{1, 0, 1, 32'h009, 32'h66666666, 32'h0,        1,  1, 32'h0,        0,  0,  1, 0, 0});
        tbl.push_back('{1, 1, 0, 32'h500, 32'h0,        32'h77777777, 0,  1, 32'h0,        17, 16, 0, 1, 17});
        tbl.push_back('{1, 1, 0, 32'h504, 32'h0,        32'h00000077, 1,  1, 32'h00000077, 2,  1,  0, 1, 2});

        // Reset state
        #12;
        @(negedge clk);
        chk("reset mem_req", bus.mem_req, 0);
        chk("reset stall_o", stall_o, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset timeout_o", timeout_o, 0);
        chk("reset mem_addr", bus.mem_addr, 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_txn(tbl[i], o);
            check_txn($sformatf("vec%0d", i), tbl[i], o);
        end
        model_to = 1'b1;

        // Asynchronous reset in the middle of a transaction
        @(posedge clk); #1;
        in_valid = 1'b1; in_rd = 1'b1; in_wr = 1'b0; in_addr = 32'h600;
        repeat (3) @(negedge clk);
        chk("mid_busy mem_req", bus.mem_req, 1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst mem_req", bus.mem_req, 0);
        chk("async_rst out_valid", out_valid, 0);
        chk("async_rst timeout_o", timeout_o, 0);
        model_to = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Spurious ack while idle must not start anything
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF0000;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ack mem_req", bus.mem_req, 0);
            chk("idle_ack out_valid", out_valid, 0);
            chk("idle_ack stall_o", stall_o, 0);
        end
        bus.mem_ack = 1'b0;

        v = '{1, 1, 0, 32'h700, 32'h0, 32'h13579BDF, 2, 0, 0, 0, 0, 0, 0, 0};
        e = model(v);
        run_txn(v, o);
        check_txn("post_reset", e, o);

        // Randomized transactions against the model
        for (int n = 0; n < 30; n++) begin
            v.valid = ($urandom_range(0, 9) != 0);
            v.rd    = $urandom_range(0, 1) != 0;
            v.wr    = $urandom_range(0, 1) != 0;
            v.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.lat   = $urandom_range(0, TIMEOUT + 2);
            e = model(v);
            run_txn(v, o);
            check_txn($sformatf("rand%0d", n), e, o);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
